// File: rtl/hilo_div_controller.sv
// rtl/hilo_div_controller.sv - multi-cycle restoring divider sequencer feeding the HI/LO pair
// Optional build macro: DIV_EARLY_OUT_EN (|a| < |b| commits in one cycle without running).
module hilo_div_controller #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            unsign,
    input  logic            hiloRead,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic [BITS-1:0] hi,
    output logic [BITS-1:0] lo,
    output logic            divideByZero
);

    localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t          state;
    state_t          nextState;
    logic [CW-1:0]   count;
    logic            fixPhase;
    logic [BITS:0]   rem;
    logic [BITS-1:0] quo;
    logic [BITS-1:0] dvsr;
    logic            qSign;
    logic            rSign;

    logic            quickPending;
    logic [BITS-1:0] quickHi;
    logic [BITS-1:0] quickLo;
    logic            quickDbz;

    logic [BITS-1:0] aMag;
    logic [BITS-1:0] bMag;
    logic            bZero;
    logic            quick;
    logic [BITS:0]   shifted;
    logic [BITS:0]   trial;

    // Magnitudes use two's-complement absolute value only for signed ops.
    always_comb begin
        aMag  = (!unsign && a[BITS-1]) ? -a : a;
        bMag  = (!unsign && b[BITS-1]) ? -b : b;
        bZero = (b == '0);
`ifdef DIV_EARLY_OUT_EN
        quick = bZero || (aMag < bMag);
`else
        quick = bZero;
`endif
    end

    always_comb begin
        shifted = {rem[BITS-1:0], quo[BITS-1]};
        trial   = shifted - {1'b0, dvsr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start && !quick) nextState = RUN;
            RUN:     if (count == '0) nextState = FIXUP;
            FIXUP:   if (fixPhase) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        stall = busy & hiloRead;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            fixPhase     <= 1'b0;
            rem          <= '0;
            quo          <= '0;
            dvsr         <= '0;
            qSign        <= 1'b0;
            rSign        <= 1'b0;
            quickPending <= 1'b0;
            quickHi      <= '0;
            quickLo      <= '0;
            quickDbz     <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            divideByZero <= 1'b0;
            done         <= 1'b0;
        end else begin
            done         <= 1'b0;
            quickPending <= 1'b0;
            // Bypassed ops (zero divisor, early-out) commit one cycle after acceptance.
            if (quickPending) begin
                hi           <= quickHi;
                lo           <= quickLo;
                divideByZero <= quickDbz;
                done         <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (quick) begin
                            quickPending <= 1'b1;
                            quickHi      <= a;
                            quickLo      <= bZero ? '1 : '0;
                            quickDbz     <= bZero;
                        end else begin
                            rem      <= '0;
                            quo      <= aMag;
                            dvsr     <= bMag;
                            qSign    <= ~unsign & (a[BITS-1] ^ b[BITS-1]);
                            rSign    <= ~unsign & a[BITS-1];
                            count    <= CW'(BITS - 1);
                            fixPhase <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem   <= trial[BITS] ? shifted : trial;
                    quo   <= {quo[BITS-2:0], ~trial[BITS]};
                    count <= count - CW'(1);
                end
                FIXUP: begin
                    // Sign correction is registered first, then committed on the next edge.
                    if (!fixPhase) begin
                        quo      <= qSign ? -quo : quo;
                        rem      <= rSign ? -rem : rem;
                        fixPhase <= 1'b1;
                    end else begin
                        lo           <= quo;
                        hi           <= rem[BITS-1:0];
                        divideByZero <= 1'b0;
                        done         <= 1'b1;
                        fixPhase     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_controller.sv
// tb/tb_hilo_div_controller.sv - directed self-checking bench for hilo_div_controller
module tb_hilo_div_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        unsign;
    logic        hiloRead;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divideByZero;

    int compared   = 0;
    int mismatched = 0;

    hilo_div_controller #(.BITS(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .unsign(unsign),
        .hiloRead(hiloRead),
        .busy(busy),
        .done(done),
        .stall(stall),
        .hi(hi),
        .lo(lo),
        .divideByZero(divideByZero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issues one op (in the current cycle) and waits for done; checks latency and results.
    task automatic doDiv(input string tag, input logic [31:0] da, input logic [31:0] db,
                         input logic du, input int expLat, input logic [31:0] expLo,
                         input logic [31:0] expHi, input logic expDbz);
        int lat;
        logic sawBusy;
        start  = 1'b1;
        a      = da;
        b      = db;
        unsign = du;
        tick();
        start   = 1'b0;
        lat     = 0;
        sawBusy = busy;
        while (!done && lat < 60) begin
            tick();
            lat++;
            sawBusy = sawBusy | busy;
        end
        check({tag, "_lat"}, lat, expLat);
        check({tag, "_lo"}, lo, expLo);
        check({tag, "_hi"}, hi, expHi);
        check({tag, "_dbz"}, {31'd0, divideByZero}, {31'd0, expDbz});
        check({tag, "_busy"}, {31'd0, sawBusy}, {31'd0, expLat > 1});
    endtask

    initial begin
        logic sawDone;
        int   eoLat;
        reset    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        unsign   = 1'b0;
        hiloRead = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_dbz", {31'd0, divideByZero}, 32'd0);
        reset = 1'b0;
        tick();

        // Unsigned 100/7 with an ignored start at E0+5 and hiloRead probes.
        start  = 1'b1;
        a      = 32'd100;
        b      = 32'd7;
        unsign = 1'b1;
        tick();
        start = 1'b0;
        check("u100_busy0", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 34; k++) begin
            start = (k == 5);
            a     = (k == 5) ? 32'd55 : 32'd100;
            b     = (k == 5) ? 32'd3 : 32'd7;
            tick();
            start = 1'b0;
            if (k == 10) begin
                hiloRead = 1'b1;
                #1;
                check("stall_busy", {31'd0, stall}, 32'd1);
                hiloRead = 1'b0;
            end
            if (k < 34) begin
                check("u100_busy", {31'd0, busy}, 32'd1);
                check("u100_nodone", {31'd0, done}, 32'd0);
            end else begin
                check("u100_done", {31'd0, done}, 32'd1);
                check("u100_busyfall", {31'd0, busy}, 32'd0);
                check("u100_lo", lo, 32'd14);
                check("u100_hi", hi, 32'd2);
                check("u100_dbz", {31'd0, divideByZero}, 32'd0);
                hiloRead = 1'b1;
                #1;
                check("stall_done", {31'd0, stall}, 32'd0);
                hiloRead = 1'b0;
            end
        end
        tick();
        check("u100_pulse", {31'd0, done}, 32'd0);
        check("u100_hold_lo", lo, 32'd14);
        check("u100_hold_hi", hi, 32'd2);

        // Back-to-back: each doDiv after the first starts in the previous done cycle.
        doDiv("sneg7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        doDiv("uFF_2", 32'hFFFF_FFFF, 32'd2, 1'b1, 34, 32'h7FFF_FFFF, 32'd1, 1'b0);
        doDiv("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 34, 32'h8000_0000, 32'd0, 1'b0);
        doDiv("dbz", 32'h0000_1234, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
        doDiv("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b0, 34, 32'hFFFF_FFFD, 32'd1, 1'b0);
`ifdef DIV_EARLY_OUT_EN
        eoLat = 1;
`else
        eoLat = 34;
`endif
        doDiv("u3_9", 32'd3, 32'd9, 1'b0, eoLat, 32'd0, 32'd3, 1'b0);
        tick();

        // Reset mid-operation at E0+10.
        start  = 1'b1;
        a      = 32'd1000;
        b      = 32'd3;
        unsign = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_hi", hi, 32'd0);
        check("mrst_lo", lo, 32'd0);
        check("mrst_dbz", {31'd0, divideByZero}, 32'd0);
        sawDone = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            sawDone = sawDone | done | busy;
        end
        check("mrst_quiet", {31'd0, sawDone}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hilo_div_controller.md
# hilo_div_controller

Multi-cycle sequencer for the integer divide path feeding the HI/LO register pair. Accepts DIV/DIVU issue requests, runs one restoring-division step per clock, applies sign correction, and commits quotient to LO and remainder to HI. Sits beside the single-cycle ALU and stalls the pipeline when an MFHI/MFLO read arrives while a divide is still in flight.

## Interface

**Parameters**
- `BITS`, 32, operand, quotient and remainder width.

**Ports**
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  issue request; accepted only when `busy`=0.
- `a`  in  BITS  dividend, sampled on the accepting edge.
- `b`  in  BITS  divisor, sampled on the accepting edge.
- `unsign`  in  1  1 = DIVU, 0 = DIV; sampled on the accepting edge.
- `hiloRead`  in  1  MFHI/MFLO in decode this cycle.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result.
- `stall`  out  1  `busy & hiloRead`, combinational.
- `hi`  out  BITS  remainder register.
- `lo`  out  BITS  quotient register.
- `divideByZero`  out  1  latched flag for the last completed op.

## Operation

- **Reset values:** `busy`=0, `done`=0, `hi`=0, `lo`=0, `divideByZero`=0, state=IDLE.
- **States:** IDLE, RUN, FIXUP.
- **IDLE:**
  - On `start` with `b`≠0: latch magnitudes |a| and |b|. For signed ops these are two's-complement absolutes.
  - Latch quotient sign = a[BITS-1]^b[BITS-1] and remainder sign = a[BITS-1]. Both signs are forced to 0 when `unsign`=1.
  - Load step counter = BITS-1, then go to RUN.
- **RUN:**
  - Each cycle: shift {partial remainder, dividend} left by 1 and trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift in a quotient bit of 1; otherwise shift in 0.
  - The partial remainder is BITS+1 bits wide.
  - The counter decrements each cycle; go to FIXUP after the counter=0 step.
- **FIXUP:**
  - Negate the quotient if its sign bit is set; negate the remainder if its sign bit is set.
  - Write `lo`←quotient and `hi`←remainder, clear `divideByZero`, pulse `done`, return to IDLE.
- **Arithmetic rules:**
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed −2^(BITS-1) / −1 yields `lo`=0x80000000 and `hi`=0, wrapping with no flag.
- **Divide by zero** (`start` with `b`=0):
  - Bypasses RUN: `lo`←all ones, `hi`←`a`, `divideByZero`←1.
  - `done` pulses on the next cycle; `busy` never asserts.
- **`start` while busy:** ignored; operands are not re-sampled.
- **`start` in the `done` cycle:** accepted, since `busy`=0 then.
- **Reset mid-operation:** aborts immediately. All outputs return to reset values and no `done` pulse is produced.
- **Hold:** `hi`, `lo` and `divideByZero` change only on commit or reset.

## Timing

- Start accepted at edge E0 (normal path):
  - RUN occupies cycles E0+1 … E0+BITS.
  - FIXUP is cycle E0+BITS+1.
  - `hi`/`lo`/`done` update at edge E0+BITS+2, so latency is BITS+2 cycles (34 for BITS=32).
- `busy` rises after E0 and falls at the same edge `done` rises.
- Divide-by-zero path: result and `done` appear after E0+1.
- Throughput: one divide per BITS+2 cycles when back-to-back starts are issued in the `done` cycle.
- `stall` has zero latency from `hiloRead`.

## Configuration

- **`DIV_EARLY_OUT_EN` defined:**
  - In IDLE, if |a| < |b| (magnitudes as latched above, `b`≠0), bypass RUN/FIXUP.
  - Commit `lo`←0 and `hi`←`a` with a 1-cycle latency, identical in timing to the divide-by-zero path; `busy` never asserts.
- **Undefined:** all nonzero-divisor ops take the full BITS+2 cycles.

## Test plan

- Unsigned 100/7, `start` at E0 → `busy` during E0+1…E0+33; `done` at E0+34 with `lo`=14, `hi`=2, `divideByZero`=0.
- Signed −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; same op with `unsign`=1 on 0xFFFFFFFF/2 → `lo`=0x7FFFFFFF, `hi`=1.
- Signed 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, no flag.
- `b`=0, `a`=0x1234 → `done` at E0+1, `lo`=0xFFFFFFFF, `hi`=0x1234, `divideByZero`=1, `busy` stays 0.
- Second `start` with different operands at E0+5 → ignored, and the first result is unchanged. `hiloRead`=1 at E0+10 → `stall`=1; `hiloRead`=1 in the `done` cycle → `stall`=0.
- `reset` at E0+10 → next cycle all outputs 0, no `done` at E0+34.
- With `DIV_EARLY_OUT_EN`: 3/9 → `done` at E0+1, `lo`=0, `hi`=3.
